video_timing_gen: RTL and testbench

//  Parametrised multi-mode video timing generator; drives HDMI TX sync/DE and pixel coordinates.

---
 rtl/video_timing_pkg.sv | 60 ++++++
 rtl/timing_axis_counter.sv | 45 ++++
 rtl/video_timing_gen.sv | 156 +++++++++++++++
 tb/tb_video_timing_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Mode table and timing helpers shared by the video timing generator and its axis counters.
// Each mode is described per axis as active/front-porch/sync/back-porch lengths plus sync polarity.
package video_timing_pkg;

  localparam int TBL_W     = 12;
  localparam int TBL_MODES = 4;

  localparam int MODE_640X480P60   = 0;
  localparam int MODE_800X600P60   = 1;
  localparam int MODE_1280X720P60  = 2;
  localparam int MODE_1920X1080P60 = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } vt_state_e;

  typedef struct packed {
    logic [TBL_W-1:0] act;
    logic [TBL_W-1:0] fp;
    logic [TBL_W-1:0] sync;
    logic [TBL_W-1:0] bp;
    logic             pol;   // 1 = sync asserted high
  } axis_cfg_t;

  typedef struct packed {
    axis_cfg_t h;
    axis_cfg_t v;
  } mode_cfg_t;

  localparam mode_cfg_t MODE_TBL [TBL_MODES] = '{
    '{h: '{act: 12'd640,  fp: 12'd16,  sync: 12'd96,  bp: 12'd48,  pol: 1'b0},
      v: '{act: 12'd480,  fp: 12'd10,  sync: 12'd2,   bp: 12'd33,  pol: 1'b0}},
    '{h: '{act: 12'd800,  fp: 12'd40,  sync: 12'd128, bp: 12'd88,  pol: 1'b1},
      v: '{act: 12'd600,  fp: 12'd1,   sync: 12'd4,   bp: 12'd23,  pol: 1'b1}},
    '{h: '{act: 12'd1280, fp: 12'd110, sync: 12'd40,  bp: 12'd220, pol: 1'b1},
      v: '{act: 12'd720,  fp: 12'd5,   sync: 12'd5,   bp: 12'd20,  pol: 1'b1}},
    '{h: '{act: 12'd1920, fp: 12'd88,  sync: 12'd44,  bp: 12'd148, pol: 1'b1},
      v: '{act: 12'd1080, fp: 12'd4,   sync: 12'd5,   bp: 12'd36,  pol: 1'b1}}
  };

  function automatic logic [TBL_W-1:0] axis_total(input axis_cfg_t c);
    return c.act + c.fp + c.sync + c.bp;
  endfunction

  function automatic logic [TBL_W-1:0] axis_sync_start(input axis_cfg_t c);
    return c.act + c.fp;
  endfunction

  function automatic logic [TBL_W-1:0] axis_sync_end(input axis_cfg_t c);
    return c.act + c.fp + c.sync;
  endfunction

  // Out-of-table indices fall back to entry 0; the top never applies one.
  function automatic mode_cfg_t mode_lookup(input logic [31:0] idx);
    return (idx < TBL_MODES) ? MODE_TBL[idx[1:0]] : MODE_TBL[0];
  endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One timing axis: counts 0..total-1 while running, decodes active area and sync level.
// Held at zero whenever run is low so every start begins at the first pixel/line.
module timing_axis_counter
  import video_timing_pkg::*;
#(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  axis_cfg_t        cfg,
  output logic [CNT_W-1:0] cnt,
  output logic             last,
  output logic             active,
  output logic             sync_lvl
);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CNT_W-1:0] tot_m1, act_len, ss, se;
  logic             sync_on;

  assign tot_m1  = CNT_W'(axis_total(cfg) - 12'd1);
  assign act_len = CNT_W'(cfg.act);
  assign ss      = CNT_W'(axis_sync_start(cfg));
  assign se      = CNT_W'(axis_sync_end(cfg));

  assign last     = (cnt_q == tot_m1);
  assign active   = run && (cnt_q < act_len);
  assign sync_on  = run && (cnt_q >= ss) && (cnt_q < se);
  assign sync_lvl = sync_on ? cfg.pol : ~cfg.pol;
  assign cnt      = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (!run)      cnt_d = '0;
    else if (step) cnt_d = last ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/video_timing_gen.sv
// Multi-mode video timing generator: run/drain FSM, frame-aligned mode switching and
// registered sync/DE/coordinate outputs driven from two axis counters.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CNT_W     = 12,
  parameter int NUM_MODES = 4,
  parameter int MODE_W    = 2,
  parameter int INIT_MODE = 0
) (
  input  logic              pixel_clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [MODE_W-1:0] mode_sel,
  input  logic              mode_req,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [CNT_W-1:0]  x,
  output logic [CNT_W-1:0]  y,
  output logic              frame_start,
  output logic              line_start,
  output logic [MODE_W-1:0] cur_mode,
  output logic              mode_pending,
  output logic              mode_err
);

  localparam logic INIT_HPOL = mode_lookup(32'(INIT_MODE)).h.pol;
  localparam logic INIT_VPOL = mode_lookup(32'(INIT_MODE)).v.pol;

  vt_state_e         state_q, state_d;
  logic [MODE_W-1:0] cur_mode_q, cur_mode_d;
  logic [MODE_W-1:0] pend_idx_q, pend_idx_d;
  logic              pend_q, pend_d;
  logic              err_q, err_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d;
  logic              de_q, de_d;
  logic [CNT_W-1:0]  x_q, x_d, y_q, y_d;
  logic              fs_q, fs_d, ls_q, ls_d;

  mode_cfg_t         cfg;
  logic              running, frame_wrap, req_ok;
  logic [CNT_W-1:0]  h_cnt, v_cnt;
  logic              h_last, v_last, h_act, v_act, h_lvl, v_lvl;

  assign cfg        = mode_lookup(32'(cur_mode_q));
  assign running    = (state_q != ST_IDLE);
  assign frame_wrap = running && h_last && v_last;
  assign req_ok     = (int'(mode_sel) < NUM_MODES);

  timing_axis_counter #(.CNT_W(CNT_W)) u_h (
    .clk      (pixel_clock),
    .reset    (reset),
    .run      (running),
    .step     (1'b1),
    .cfg      (cfg.h),
    .cnt      (h_cnt),
    .last     (h_last),
    .active   (h_act),
    .sync_lvl (h_lvl)
  );

  timing_axis_counter #(.CNT_W(CNT_W)) u_v (
    .clk      (pixel_clock),
    .reset    (reset),
    .run      (running),
    .step     (h_last),
    .cfg      (cfg.v),
    .cnt      (v_cnt),
    .last     (v_last),
    .active   (v_act),
    .sync_lvl (v_lvl)
  );

  // Mode latch: a request arriving on the apply cycle itself takes effect at once.
  always_comb begin
    pend_idx_d = pend_idx_q;
    pend_d     = pend_q;
    err_d      = err_q;
    cur_mode_d = cur_mode_q;
    if (mode_req && req_ok) begin
      pend_idx_d = mode_sel;
      pend_d     = 1'b1;
    end
    if (mode_req && !req_ok) err_d = 1'b1;
    if ((!running || frame_wrap) && pend_d) begin
      cur_mode_d = pend_idx_d;
      pend_d     = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = frame_wrap ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (enable)          state_d = ST_RUN;
        else if (frame_wrap) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hsync_d = h_lvl;
    vsync_d = v_lvl;
    de_d    = h_act && v_act;
    x_d     = de_d ? h_cnt : '0;
    y_d     = de_d ? v_cnt : '0;
    ls_d    = running && (h_cnt == '0);
    fs_d    = ls_d && (v_cnt == '0);
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cur_mode_q <= MODE_W'(INIT_MODE);
      pend_idx_q <= '0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      hsync_q    <= ~INIT_HPOL;
      vsync_q    <= ~INIT_VPOL;
      de_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      fs_q       <= 1'b0;
      ls_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_mode_q <= cur_mode_d;
      pend_idx_q <= pend_idx_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      de_q       <= de_d;
      x_q        <= x_d;
      y_q        <= y_d;
      fs_q       <= fs_d;
      ls_q       <= ls_d;
    end
  end

  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign de           = de_q;
  assign x            = x_q;
  assign y            = y_q;
  assign frame_start  = fs_q;
  assign line_start   = ls_q;
  assign cur_mode     = cur_mode_q;
  assign mode_pending = pend_q;
  assign mode_err     = err_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench: a frame-position reference model (pixel index n -> h,v by division)
// predicts every output each cycle; directed line scans check porch/sync placement per mode.
module tb_video_timing_gen;

  localparam int CNT_W = 12;
  localparam int NM    = 4;
  localparam int MW    = 3;   // wider than needed so indices 4..7 exercise mode_err
  localparam int INIT  = 0;

  localparam int HACT [4] = '{640, 800, 1280, 1920};
  localparam int HFP  [4] = '{16, 40, 110, 88};
  localparam int HSY  [4] = '{96, 128, 40, 44};
  localparam int HBP  [4] = '{48, 88, 220, 148};
  localparam int VACT [4] = '{480, 600, 720, 1080};
  localparam int VFP  [4] = '{10, 1, 5, 4};
  localparam int VSY  [4] = '{2, 4, 5, 5};
  localparam int VBP  [4] = '{33, 23, 20, 36};
  localparam int POL  [4] = '{0, 1, 1, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, en, req;
  logic [MW-1:0]    sel;
  logic             hsync, vsync, de, frame_start, line_start, mode_pending, mode_err;
  logic [CNT_W-1:0] x, y;
  logic [MW-1:0]    cur_mode;

  video_timing_gen #(.CNT_W(CNT_W), .NUM_MODES(NM), .MODE_W(MW), .INIT_MODE(INIT)) dut (
    .pixel_clock  (clk),
    .reset        (rst),
    .enable       (en),
    .mode_sel     (sel),
    .mode_req     (req),
    .hsync        (hsync),
    .vsync        (vsync),
    .de           (de),
    .x            (x),
    .y            (y),
    .frame_start  (frame_start),
    .line_start   (line_start),
    .cur_mode     (cur_mode),
    .mode_pending (mode_pending),
    .mode_err     (mode_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model: ms 0=idle 1=run 2=drain, n = pixel index within the frame
  int          ms, n, mmode, mpidx;
  bit          mpend, merr;
  logic [28:0] e_out;
  logic [4:0]  e_mode;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [28:0] pack_out(input bit hs, input bit vs, input bit d, input bit fs,
                                           input bit ls, input int xx, input int yy);
    return {hs, vs, d, fs, ls, 12'(xx), 12'(yy)};
  endfunction

  task automatic model_step();
    int htot, vtot, h, v;
    bit hs_on, vs_on, dd, wrap;
    if (rst) begin
      ms = 0; n = 0; mmode = INIT; mpend = 0; mpidx = 0; merr = 0;
      e_out = pack_out(POL[INIT] == 0, POL[INIT] == 0, 0, 0, 0, 0, 0);
    end else begin
      htot = HACT[mmode] + HFP[mmode] + HSY[mmode] + HBP[mmode];
      vtot = VACT[mmode] + VFP[mmode] + VSY[mmode] + VBP[mmode];
      h = n % htot;
      v = n / htot;
      if (ms != 0) begin
        dd    = (h < HACT[mmode]) && (v < VACT[mmode]);
        hs_on = (h >= HACT[mmode] + HFP[mmode]) && (h < HACT[mmode] + HFP[mmode] + HSY[mmode]);
        vs_on = (v >= VACT[mmode] + VFP[mmode]) && (v < VACT[mmode] + VFP[mmode] + VSY[mmode]);
        e_out = pack_out(hs_on == (POL[mmode] != 0), vs_on == (POL[mmode] != 0), dd,
                         n == 0, h == 0, dd ? h : 0, dd ? v : 0);
      end else begin
        e_out = pack_out(POL[mmode] == 0, POL[mmode] == 0, 0, 0, 0, 0, 0);
      end
      wrap = (ms != 0) && (n == htot * vtot - 1);
      if (req) begin
        if (int'(sel) < NM) begin mpend = 1; mpidx = int'(sel); end
        else merr = 1;
      end
      if ((ms == 0 || wrap) && mpend) begin mmode = mpidx; mpend = 0; end
      if (ms == 0) begin
        if (en) ms = 1;
      end else begin
        n  = wrap ? 0 : n + 1;
        ms = (wrap && !en) ? 0 : (en ? 1 : 2);
      end
    end
    e_mode = {3'(mmode), mpend, merr};
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("outs", 64'({hsync, vsync, de, frame_start, line_start, x, y}), 64'(e_out));
    chk("mode", 64'({cur_mode, mode_pending, mode_err}), 64'(e_mode));
  endtask

  task automatic run(input int cycles, input int p_req, input int p_dip, input bit p_rst);
    int dip = 0;
    for (int i = 0; i < cycles; i++) begin
      req = ($urandom_range(999) < p_req);
      sel = MW'($urandom_range(7));
      if (dip == 0 && $urandom_range(999) < p_dip) dip = $urandom_range(1, 40);
      en  = (dip == 0);
      if (dip > 0) dip--;
      rst = p_rst && ($urandom_range(1999) == 0);
      tick();
    end
    req = 0; rst = 0; en = 1;
  endtask

  // Scans the first line after frame_start and checks DE and hsync placement for mode m.
  task automatic line_check(input int m);
    int k = 0, de_cnt = 0, hs_cnt = 0, hs_pos = -1, ls_cnt = 0, htot;
    htot = HACT[m] + HFP[m] + HSY[m] + HBP[m];
    while (!frame_start && k < 8) begin tick(); k++; end
    chk("fs_seen", 64'(frame_start), 64'(1));
    for (int i = 0; i < htot; i++) begin
      if (i > 0) tick();
      if (de) de_cnt++;
      if (line_start) ls_cnt++;
      if (hsync == (POL[m] != 0)) begin
        hs_cnt++;
        if (hs_pos < 0) hs_pos = i;
      end
    end
    chk("de_cnt", 64'(de_cnt), 64'(HACT[m]));
    chk("hs_len", 64'(hs_cnt), 64'(HSY[m]));
    chk("hs_pos", 64'(hs_pos), 64'(HACT[m] + HFP[m]));
    chk("ls_cnt", 64'(ls_cnt), 64'(1));
  endtask

  task automatic idle_select(input int m);
    en = 0; req = 1; sel = MW'(m);
    tick();
    req = 0;
    tick();
    chk("idle_apply", 64'(cur_mode), 64'(m));
  endtask

  initial begin
    rst = 1; en = 0; req = 0; sel = '0;
    repeat (3) tick();
    rst = 0;

    // idle: immediate apply and invalid-index detection
    for (int i = 0; i < 30; i++) begin
      req = $urandom_range(1) == 1;
      sel = MW'($urandom_range(7));
      tick();
    end
    req = 1; sel = MW'(5);
    tick();
    req = 0;
    chk("err_sticky", 64'(mode_err), 64'(1));
    rst = 1;
    tick();
    rst = 0;
    chk("err_clr", 64'(mode_err), 64'(0));

    // mode 0 from reset, then a pending switch that must wait for frame end
    en = 1;
    line_check(0);
    req = 1; sel = MW'(2);
    tick();
    req = 0;
    run(1600, 0, 0, 0);
    chk("pend_held", 64'({cur_mode, mode_pending}), 64'({3'd0, 1'b1}));
    run(3000, 5, 3, 0);

    // mode 1, then reset mid-frame
    rst = 1; tick(); rst = 0;
    idle_select(1);
    en = 1;
    line_check(1);
    run(500, 0, 0, 0);
    rst = 1; tick(); rst = 0; en = 0;
    chk("rst_mode", 64'(cur_mode), 64'(INIT));
    tick();

    idle_select(3);
    en = 1;
    line_check(3);
    run(2400, 3, 2, 0);

    rst = 1; tick(); rst = 0;
    idle_select(2);
    en = 1;
    line_check(2);
    run(1000, 3, 3, 0);

    run(6000, 8, 5, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
